// File: rtl/to_ram_xfer_if.sv
// Bundle of HPS control/status, upstream event FIFO and SoC FIFO-read signals
// for the to_ram transfer sequencer. master = sequencer side.
interface to_ram_xfer_if;
    logic [31:0] ctrl_from_hps;
    logic [31:0] status_to_hps;
    logic        ram_enable;
    logic [31:0] ev_data;
    logic        ev_empty;
    logic        ev_rdreq;
    logic [31:0] fifo_data_event;
    logic        fifo_data_empty;
    logic        fifo_data_ack;

    modport master (
        input  ctrl_from_hps, ev_data, ev_empty, fifo_data_ack,
        output status_to_hps, ram_enable, ev_rdreq, fifo_data_event, fifo_data_empty
    );

    modport slave (
        output ctrl_from_hps, ev_data, ev_empty, fifo_data_ack,
        input  status_to_hps, ram_enable, ev_rdreq, fifo_data_event, fifo_data_empty
    );
endinterface

// File: rtl/to_ram_xfer_ctrl.sv
// Sequencer for the HPS to_ram event path: tag-handshaked commands, exactly-LEN
// word transfer from a show-ahead FIFO to the SoC read port, stall watchdog.
module to_ram_xfer_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_W          = 16
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    to_ram_xfer_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, ERROR = 2'd3} state_t;

    state_t           state, state_nxt;
    logic [7:0]       last_tag;
    logic [CNT_W-1:0] len_r, issued, done_cnt;
    logic [31:0]      stall_cnt;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             proto_err, aborted, done_flag;
    logic [1:0]       err_code;
    logic [31:0]      status_r;

    logic             cmd_start, cmd_abort, new_tag, start_acc, tag_latch;
    logic [7:0]       cmd_tag;
    logic [CNT_W-1:0] cmd_len;
    logic             pop, ack_v, ack_bad, last_ack, timeout;

    assign cmd_start = bus.ctrl_from_hps[0];
    assign cmd_abort = bus.ctrl_from_hps[1];
    assign cmd_tag   = bus.ctrl_from_hps[15:8];
    assign cmd_len   = bus.ctrl_from_hps[16 +: CNT_W];
    assign new_tag   = cmd_tag != last_tag;

    // A START arriving mid-RUN is left pending (tag not consumed) until the run ends.
    assign start_acc = !cmd_abort && new_tag && cmd_start && (state != RUN);
    assign tag_latch = new_tag && (cmd_abort || !cmd_start || (state != RUN));

    assign ack_v    = bus.fifo_data_ack && out_valid;
    assign ack_bad  = bus.fifo_data_ack && !out_valid;
    assign pop      = reset_reset_n && !cmd_abort && (state == RUN) && !bus.ev_empty &&
                      (issued < len_r) && (!out_valid || bus.fifo_data_ack);
    assign last_ack = (state == RUN) && ack_v && ((done_cnt + CNT_W'(1)) == len_r);
    assign timeout  = (TIMEOUT_CYCLES != 0) && (state == RUN) && out_valid &&
                      !bus.fifo_data_ack && ((stall_cnt + 32'd1) == TIMEOUT_CYCLES);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) state <= IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cmd_abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                RUN: begin
                    if (timeout)       state_nxt = ERROR;
                    else if (last_ack) state_nxt = DONE;
                end
                default: begin
                    if (start_acc) state_nxt = (cmd_len == '0) ? ERROR : RUN;
                end
            endcase
        end
    end

    always_comb begin
        bus.ram_enable      = (state == RUN);
        bus.ev_rdreq        = pop;
        bus.fifo_data_empty = !out_valid;
        bus.fifo_data_event = out_valid ? out_data : 32'h0;
        bus.status_to_hps   = status_r;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            last_tag  <= '0;
            len_r     <= '0;
            issued    <= '0;
            done_cnt  <= '0;
            stall_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            proto_err <= 1'b0;
            aborted   <= 1'b0;
            done_flag <= 1'b0;
            err_code  <= 2'd0;
            status_r  <= '0;
        end else begin
            if (tag_latch) last_tag <= cmd_tag;

            if (cmd_abort) begin
                // Any popped-but-unacked word is dropped here.
                out_valid <= 1'b0;
                stall_cnt <= '0;
                aborted   <= 1'b1;
                if (ack_bad) proto_err <= 1'b1;
            end else if (start_acc) begin
                len_r     <= cmd_len;
                issued    <= '0;
                done_cnt  <= '0;
                stall_cnt <= '0;
                out_valid <= 1'b0;
                proto_err <= 1'b0;
                aborted   <= 1'b0;
                done_flag <= 1'b0;
                err_code  <= (cmd_len == '0) ? 2'd1 : 2'd0;
            end else begin
                if (ack_bad) proto_err <= 1'b1;
                if (pop) begin
                    out_data  <= bus.ev_data;
                    out_valid <= 1'b1;
                    issued    <= issued + CNT_W'(1);
                end else if (ack_v) begin
                    out_valid <= 1'b0;
                end
                if (ack_v)    done_cnt  <= done_cnt + CNT_W'(1);
                if (last_ack) done_flag <= 1'b1;
                if (timeout) begin
                    out_valid <= 1'b0;
                    err_code  <= 2'd2;
                end
                stall_cnt <= (!out_valid || bus.fifo_data_ack) ? 32'd0 : stall_cnt + 32'd1;
            end

            status_r <= {16'(done_cnt), last_tag, proto_err, aborted, err_code,
                         done_flag, 1'b0, state};
        end
    end
endmodule

// File: tb/tb_to_ram_xfer_ctrl.sv
// Bench for to_ram_xfer_ctrl: command table, hand-written transfer scenarios and
// randomized transfers scored against an in-order word stream model.
`timescale 1ns/1ps
module tb_to_ram_xfer_ctrl;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    to_ram_xfer_if bus();

    to_ram_xfer_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .bus          (bus)
    );

    typedef struct {
        logic [31:0] ctrl;
        bit          ack;
        logic [31:0] st;
        bit          ren;
        bit          emp;
    } vec_t;

    vec_t        tbl[12];
    int          checks = 0, errors = 0;
    logic [31:0] src_q[$], got_q[$], exp_q[$];
    logic [31:0] ctrl_v = 32'h0, prev_data = 32'h0;
    bit          rst_req = 1'b1, hold_src = 1'b0, ack_en = 1'b0, ack_force = 1'b0, rand_ack = 1'b0;
    bit          prev_shown = 1'b0, last_rdreq = 1'b0;
    int          ack_every = 1, cyc_cnt = 0, pop_cnt = 0, ren_cnt = 0, ack_cnt = 0, stall_tb = 0;

    initial begin
        bus.ctrl_from_hps = 32'h0;
        bus.ev_data       = 32'h0;
        bus.ev_empty      = 1'b1;
        bus.fifo_data_ack = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One clock: drive at negedge, observe #1 later, update source queue after posedge.
    task automatic cycle();
        bit ack;
        @(negedge clk);
        rst_n             = !rst_req;
        bus.ctrl_from_hps = ctrl_v;
        bus.ev_empty      = hold_src || (src_q.size() == 0);
        bus.ev_data       = (src_q.size() != 0) ? src_q[0] : 32'h0;
        ack = ack_force || (ack_en && !bus.fifo_data_empty && (cyc_cnt % ack_every == 0));
        if (rand_ack && ack && !ack_force && stall_tb < 8 && ($urandom % 4 == 0)) ack = 1'b0;
        bus.fifo_data_ack = ack;
        #1;
        if (!bus.fifo_data_empty && rst_n) begin
            if (prev_shown) chk("hold_data", bus.fifo_data_event, prev_data);
            if (ack) begin
                got_q.push_back(bus.fifo_data_event);
                ack_cnt++;
                prev_shown = 1'b0;
                stall_tb   = 0;
            end else begin
                prev_shown = 1'b1;
                prev_data  = bus.fifo_data_event;
                stall_tb++;
            end
        end else begin
            prev_shown = 1'b0;
            stall_tb   = 0;
        end
        last_rdreq = bus.ev_rdreq;
        if (last_rdreq) pop_cnt++;
        if (bus.ram_enable) ren_cnt++;
        cyc_cnt++;
        @(posedge clk);
        if (last_rdreq && src_q.size() != 0) void'(src_q.pop_front());
    endtask

    task automatic do_reset();
        rst_req = 1'b1; ctrl_v = 32'h0; ack_en = 1'b0; ack_force = 1'b0;
        rand_ack = 1'b0; hold_src = 1'b0; ack_every = 1;
        src_q.delete(); got_q.delete();
        repeat (2) cycle();
        rst_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [15:0] last_dc;
        int          steps[$];
        int          shown;
        int          len;
        logic [7:0]  tag;
        bit          hit;

        tbl[0]  = '{32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        tbl[1]  = '{32'h0000_0500, 1'b0, 32'h0000_0500, 1'b0, 1'b1};  // tag only
        tbl[2]  = '{32'h0003_0501, 1'b0, 32'h0000_0500, 1'b0, 1'b1};  // same tag ignored
        tbl[3]  = '{32'h0000_0601, 1'b0, 32'h0000_0613, 1'b0, 1'b1};  // LEN=0
        tbl[4]  = '{32'h0000_0601, 1'b0, 32'h0000_0613, 1'b0, 1'b1};
        tbl[5]  = '{32'h0000_0602, 1'b0, 32'h0000_0650, 1'b0, 1'b1};  // abort from ERROR
        tbl[6]  = '{32'h0002_0701, 1'b0, 32'h0000_0701, 1'b1, 1'b1};  // RUN, source empty
        tbl[7]  = '{32'h0002_0701, 1'b0, 32'h0000_0701, 1'b1, 1'b1};
        tbl[8]  = '{32'h0000_0800, 1'b0, 32'h0000_0801, 1'b1, 1'b1};  // tag latch in RUN
        tbl[9]  = '{32'h0000_0802, 1'b0, 32'h0000_0840, 1'b0, 1'b1};  // abort RUN
        tbl[10] = '{32'h0000_0802, 1'b1, 32'h0000_08C0, 1'b0, 1'b1};  // ack while empty
        tbl[11] = '{32'h0000_0800, 1'b0, 32'h0000_08C0, 1'b0, 1'b1};

        // Reset state
        do_reset();
        #1;
        chk("rst_status", bus.status_to_hps, 32'h0);
        chk("rst_ren", {31'b0, bus.ram_enable}, 32'd0);
        chk("rst_empty", {31'b0, bus.fifo_data_empty}, 32'd1);
        chk("rst_event", bus.fifo_data_event, 32'h0);

        // Command table
        for (int i = 0; i < 12; i++) begin
            ctrl_v = tbl[i].ctrl; ack_force = tbl[i].ack;
            repeat (3) cycle();
            #1;
            chk($sformatf("tbl%0d_status", i), bus.status_to_hps, tbl[i].st);
            chk($sformatf("tbl%0d_ren", i), {31'b0, bus.ram_enable}, {31'b0, tbl[i].ren});
            chk($sformatf("tbl%0d_empty", i), {31'b0, bus.fifo_data_empty}, {31'b0, tbl[i].emp});
        end
        ack_force = 1'b0;

        // Basic transfer, ack every presented word
        do_reset();
        src_q = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004};
        ack_en = 1'b1; pop_cnt = 0; ren_cnt = 0; got_q.delete();
        ctrl_v = 32'h0004_0101;
        repeat (12) cycle();
        #1;
        chk("basic_pops", pop_cnt, 4);
        chk("basic_ren_cycles", ren_cnt, 5);
        chk("basic_words", got_q.size(), 4);
        if (got_q.size() == 4) begin
            chk("basic_w0", got_q[0], 32'hA000_0001);
            chk("basic_w3", got_q[3], 32'hD000_0004);
        end
        chk("basic_status", bus.status_to_hps, 32'h0004_010A);

        // Backpressure: ack only every third cycle
        src_q = '{32'h1111_0001, 32'h1111_0002, 32'h1111_0003, 32'h1111_0004, 32'h1111_0005};
        ack_every = 3; pop_cnt = 0; got_q.delete(); steps.delete();
        last_dc = bus.status_to_hps[31:16];
        ctrl_v = 32'h0003_0201;
        for (int i = 0; i < 40; i++) begin
            cycle();
            #1;
            if (bus.status_to_hps[31:16] != last_dc) begin
                last_dc = bus.status_to_hps[31:16];
                steps.push_back(int'(last_dc));
            end
        end
        chk("bp_pops", pop_cnt, 3);
        chk("bp_left_in_src", src_q.size(), 2);
        chk("bp_steps", steps.size(), 4);
        if (steps.size() == 4) chk("bp_step_seq", {steps[0][7:0], steps[1][7:0], steps[2][7:0], steps[3][7:0]},
                                   32'h0001_0203);
        if (got_q.size() == 3) chk("bp_w2", got_q[2], 32'h1111_0003);
        else chk("bp_words", got_q.size(), 3);
        chk("bp_empty_after", {31'b0, bus.fifo_data_empty}, 32'd1);
        chk("bp_status", bus.status_to_hps, 32'h0003_020A);
        ack_every = 1; src_q.delete();

        // Upstream underflow: long source gap must not trip the watchdog
        src_q = '{32'h2222_0001, 32'h2222_0002};
        got_q.delete();
        ctrl_v = 32'h0006_0301;
        repeat (55) cycle();
        #1;
        chk("uf_status_mid", bus.status_to_hps, 32'h0002_0301);
        for (int i = 3; i <= 6; i++) src_q.push_back(32'h2222_0000 + i);
        repeat (15) cycle();
        #1;
        chk("uf_status_end", bus.status_to_hps, 32'h0006_030A);
        chk("uf_words", got_q.size(), 6);
        if (got_q.size() == 6) chk("uf_w5", got_q[5], 32'h2222_0006);

        // Watchdog timeout
        src_q = '{32'h3333_0001, 32'h3333_0002};
        ack_en = 1'b0; shown = 0;
        ctrl_v = 32'h0002_0401;
        for (int i = 0; i < 40; i++) begin
            cycle();
            #1;
            if (!bus.fifo_data_empty) shown++;
        end
        chk("tmo_stall_cycles", shown, TMO);
        chk("tmo_status", bus.status_to_hps, 32'h0000_0423);
        chk("tmo_ren", {31'b0, bus.ram_enable}, 32'd0);
        src_q.delete();

        // Abort at done_cnt=2 of LEN=8, then retrigger
        for (int i = 1; i <= 8; i++) src_q.push_back(32'h4444_0000 + i);
        ack_en = 1'b1; ack_cnt = 0;
        ctrl_v = 32'h0008_0501;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            cycle();
            hit = (ack_cnt >= 2);
        end
        chk("abort_reach_two", {31'b0, hit}, 32'd1);
        ack_en = 1'b0;
        ctrl_v = 32'h0008_0503;
        repeat (3) cycle();
        #1;
        chk("abort_empty", {31'b0, bus.fifo_data_empty}, 32'd1);
        chk("abort_ren", {31'b0, bus.ram_enable}, 32'd0);
        chk("abort_status", bus.status_to_hps, 32'h0002_0540);
        src_q.delete(); got_q.delete();
        src_q.push_back(32'h5555_AAAA);
        ack_en = 1'b1;
        ctrl_v = 32'h0001_0201;
        repeat (8) cycle();
        #1;
        chk("retrig_status", bus.status_to_hps, 32'h0001_020A);
        chk("retrig_words", got_q.size(), 1);
        if (got_q.size() == 1) chk("retrig_w0", got_q[0], 32'h5555_AAAA);

        // Ack while nothing presented: flag only, counters untouched
        ack_force = 1'b1;
        cycle();
        ack_force = 1'b0;
        repeat (2) cycle();
        #1;
        chk("proto_status", bus.status_to_hps, 32'h0001_028A);

        // Reset in the middle of a streaming run
        for (int i = 1; i <= 4; i++) src_q.push_back(32'h6666_0000 + i);
        ctrl_v = 32'h0004_0601;
        repeat (3) cycle();
        rst_req = 1'b1; ctrl_v = 32'h0;
        cycle();
        chk("rst_mid_rdreq", {31'b0, last_rdreq}, 32'd0);
        #1;
        chk("rst_mid_ren", {31'b0, bus.ram_enable}, 32'd0);
        chk("rst_mid_empty", {31'b0, bus.fifo_data_empty}, 32'd1);
        chk("rst_mid_event", bus.fifo_data_event, 32'h0);
        chk("rst_mid_status", bus.status_to_hps, 32'h0);
        rst_req = 1'b0;

        // Randomized transfers against an in-order stream model
        do_reset();
        for (int r = 0; r < 6; r++) begin
            tag = 8'h10 + 8'(r);
            len = int'($urandom_range(1, 10));
            src_q.delete(); got_q.delete(); exp_q.delete();
            for (int i = 0; i < len; i++) begin
                exp_q.push_back($urandom);
                src_q.push_back(exp_q[i]);
            end
            for (int i = 0; i < 3; i++) src_q.push_back($urandom);
            pop_cnt = 0; ack_en = 1'b1; rand_ack = 1'b1;
            ctrl_v = {16'(len), tag, 8'h01};
            hit = 1'b0;
            for (int i = 0; i < 300 && !hit; i++) begin
                hold_src = ($urandom % 4 == 0);
                cycle();
                #1;
                hit = (bus.status_to_hps[2:0] == 3'd2) && (bus.status_to_hps[31:16] == 16'(len));
            end
            hold_src = 1'b0;
            chk($sformatf("rnd%0d_finished", r), {31'b0, hit}, 32'd1);
            chk($sformatf("rnd%0d_pops", r), pop_cnt, len);
            chk($sformatf("rnd%0d_words", r), got_q.size(), len);
            for (int i = 0; i < len && i < got_q.size(); i++)
                chk($sformatf("rnd%0d_w%0d", r, i), got_q[i], exp_q[i]);
            chk($sformatf("rnd%0d_status", r), bus.status_to_hps, {16'(len), tag, 8'h0A});
        end
        rand_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
